// File: rtl/rv_ctrl_pkg.sv
// Shared opcode classes, sequencer state and pipeline-control bundle for the
// RV32 hazard/sequencing logic.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_en;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_FREEZE   = pipe_ctrl_t'(7'b0000000);
  localparam pipe_ctrl_t CTRL_ADVANCE  = pipe_ctrl_t'(7'b1101011);
  localparam pipe_ctrl_t CTRL_BRANCH   = pipe_ctrl_t'(7'b1111111);
  // Hold PC and IF/ID, load a bubble into ID/EX, let the load move on.
  localparam pipe_ctrl_t CTRL_LOAD_USE = pipe_ctrl_t'(7'b0001111);

  function automatic logic uses_rs1(input logic [6:0] opcode);
    return (opcode == OP_BRANCH) || (opcode == OP_LOAD) || (opcode == OP_STORE) ||
           (opcode == OP_IMM)    || (opcode == OP_REG);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_BRANCH) || (opcode == OP_STORE) || (opcode == OP_REG);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: decodes which source registers the ID-stage
// instruction reads and compares them against the EX-stage load destination.
module hazard_detect
  import rv_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [31:0]       id_instr_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  output logic              load_use_o
);

  logic [6:0]        opcode;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic              rs1_hit;
  logic              rs2_hit;
  logic              unused_instr_bits;

  assign opcode = id_instr_i[6:0];
  assign rs1    = REG_AW'(id_instr_i[19:15]);
  assign rs2    = REG_AW'(id_instr_i[24:20]);

  assign unused_instr_bits = ^{id_instr_i[31:25], id_instr_i[14:7]};

  assign rs1_hit = uses_rs1(opcode) && (rs1 == ex_rd_i);
  assign rs2_hit = uses_rs2(opcode) && (rs2 == ex_rd_i);

  // x0 is never a real dependency even when a load targets it.
  assign load_use_o = ex_mem_read_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central 5-stage pipeline sequencer: load-use bubbles, branch flushes,
// data-memory freeze with timeout halt, and a stall-cycle counter.
module pipe_hazard_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       id_instr,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              dmem_ready,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              idex_flush,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_count
);

  ctrl_state_t      state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use;
  logic             mem_stall;
  pipe_ctrl_t       ctrl;

  hazard_detect #(
    .REG_AW(REG_AW)
  ) u_hazard_detect (
    .id_instr_i   (id_instr),
    .ex_mem_read_i(ex_mem_read),
    .ex_rd_i      (ex_rd),
    .load_use_o   (load_use)
  );

  assign mem_stall = mem_req & ~dmem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      to_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    stall_cnt_d = stall_cnt_q;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          to_cnt_d = TO_W'(1);
          state_d  = (TIMEOUT <= 1) ? HALT : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_stall) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          state_d  = (to_cnt_d == TO_W'(TIMEOUT)) ? HALT : MEM_WAIT;
        end else begin
          to_cnt_d = '0;
          state_d  = RUN;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
    // Branch flushes keep pc_en high, so they never reach this counter.
    if (state_q != HALT && !ctrl.pc_en && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // MEM_WAIT shares the RUN rules: once the stall drops, the release cycle
  // applies whatever branch or hazard is pending.
  always_comb begin
    ctrl = CTRL_FREEZE;
    if (rst_n && state_q != HALT) begin
      if (mem_stall)            ctrl = CTRL_FREEZE;
      else if (ex_branch_taken) ctrl = CTRL_BRANCH;
      else if (load_use)        ctrl = CTRL_LOAD_USE;
      else                      ctrl = CTRL_ADVANCE;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign ifid_en     = ctrl.ifid_en;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_en     = ctrl.idex_en;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_en    = ctrl.exmem_en;
  assign memwb_en    = ctrl.memwb_en;
  assign halted      = (state_q == HALT);
  assign stall_count = stall_cnt_q;

endmodule
